// File: rtl/note_gate_decoder.sv
// Note index/valid stream to registered per-channel gates (momentary+hold, toggle, latch).
// Latency: 1 cycle from request/release to dig_o and dig_chg_o.
// Backpressure: none; every input cycle is consumed.
module note_gate_decoder #(
    parameter int CH_NUM = 8,
    parameter int IDX_W  = $clog2(CH_NUM),
    parameter int HOLD_W = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [IDX_W-1:0]  num_i,
    input  logic              num_val_i,
    input  logic              off_i,
    input  logic [1:0]        mode_i,
    input  logic [HOLD_W-1:0] hold_i,
    output logic [CH_NUM-1:0] dig_o,
    output logic              dig_chg_o
);

    typedef enum logic [1:0] {
        MODE_MOM = 2'd0,
        MODE_TOG = 2'd1,
        MODE_LAT = 2'd2,
        MODE_RSV = 2'd3
    } mode_e;

    mode_e             mode_q;
    mode_e             mode_cur;
    logic              mode_chg;
    logic [CH_NUM-1:0] req;
    logic [CH_NUM-1:0] rel;
    logic [CH_NUM-1:0] p_q;
    logic [CH_NUM-1:0] p_nxt;
    logic [CH_NUM-1:0] g_nxt;
    logic [HOLD_W-1:0] cnt_q   [CH_NUM];
    logic [HOLD_W-1:0] cnt_nxt [CH_NUM];

    // Reserved mode behaves as momentary, so both map to the same class.
    function automatic logic [1:0] mode_class(input logic [1:0] m);
        return (m == MODE_RSV) ? MODE_MOM : m;
    endfunction

    assign mode_cur = mode_e'(mode_i);
    assign mode_chg = (mode_class(mode_i) != mode_class(mode_q));

    // Out-of-range indices match no channel and are silently dropped.
    always_comb begin
        req = '0;
        rel = '0;
        for (int k = 0; k < CH_NUM; k++) begin
            req[k] = num_val_i && (num_i == IDX_W'(k));
            rel[k] = off_i && !num_val_i && (num_i == IDX_W'(k));
        end
    end

    always_comb begin
        g_nxt = dig_o;
        p_nxt = req;
        for (int k = 0; k < CH_NUM; k++) begin
            cnt_nxt[k] = cnt_q[k];
        end
        if (mode_chg) begin
            g_nxt = '0;
            p_nxt = '0;
            for (int k = 0; k < CH_NUM; k++) begin
                cnt_nxt[k] = '0;
            end
        end else begin
            case (mode_cur)
                MODE_TOG: begin
                    for (int k = 0; k < CH_NUM; k++) begin
                        cnt_nxt[k] = '0;
                        if (req[k] && !p_q[k]) begin
                            g_nxt[k] = !dig_o[k];
                        end else if (rel[k]) begin
                            g_nxt[k] = 1'b0;
                        end
                    end
                end
                MODE_LAT: begin
                    for (int k = 0; k < CH_NUM; k++) begin
                        cnt_nxt[k] = '0;
                    end
                    if (|req) begin
                        g_nxt = req;
                    end else begin
                        g_nxt = dig_o & ~rel;
                    end
                end
                default: begin
                    for (int k = 0; k < CH_NUM; k++) begin
                        if (req[k]) begin
                            g_nxt[k]   = 1'b1;
                            cnt_nxt[k] = hold_i;
                        end else if (rel[k]) begin
                            g_nxt[k]   = 1'b0;
                            cnt_nxt[k] = '0;
                        end else if (cnt_q[k] != '0) begin
                            cnt_nxt[k] = cnt_q[k] - 1'b1;
                        end else begin
                            g_nxt[k] = 1'b0;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            dig_o     <= '0;
            dig_chg_o <= 1'b0;
            p_q       <= '0;
            mode_q    <= MODE_MOM;
            for (int k = 0; k < CH_NUM; k++) begin
                cnt_q[k] <= '0;
            end
        end else begin
            dig_o     <= g_nxt;
            dig_chg_o <= (g_nxt != dig_o);
            p_q       <= p_nxt;
            mode_q    <= mode_cur;
            for (int k = 0; k < CH_NUM; k++) begin
                cnt_q[k] <= cnt_nxt[k];
            end
        end
    end

endmodule
